iir1_multich: RTL

Parametrised first-order IIR filter, y(n) = b·x(n) + a·y(n−1), time-shared across CH independent channels. Pipelined multipliers, per-channel state memory and a valid/ready input handshake with hazard stalling. Coefficients are runtime-loadable. Used as the drop-in successor to the single-channel fixed-coefficient IIR stage in the DSP chain.

---
 rtl/iir1_multich.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/iir1_multich.sv
// iir1_multich: first-order IIR y = b*x + a*y_prev, time-shared over CH channels with runtime coefficients.
// Define IIR1_MULTICH_SAT_EN to saturate out_data to Y_W bits; otherwise out_data wraps (state always wraps at ACC_W).
module iir1_multich #(
    parameter  int CH      = 4,
    parameter  int X_W     = 8,
    parameter  int COEF_W  = 16,
    parameter  int ACC_W   = 24,
    parameter  int Y_W     = 18,
    parameter  int MUL_LAT = 2,
    parameter  int A_INIT  = 0,
    parameter  int B_INIT  = 0,
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CW-1:0]     in_ch,
    input  logic [X_W-1:0]    in_data,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [COEF_W-1:0] coef_a_in,
    input  logic [COEF_W-1:0] coef_b_in,
    output logic              coef_busy,
    input  logic              clr,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic [Y_W-1:0]    out_data
);
    localparam int LAST = MUL_LAT - 1;

`ifdef IIR1_MULTICH_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((32'sd1 <<< (Y_W - 1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    function automatic logic [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] v);
        logic [Y_W-1:0] r;
        if (v > Y_MAX) begin
            r = Y_MAX[Y_W-1:0];
        end else if (v < Y_MIN) begin
            r = Y_MIN[Y_W-1:0];
        end else begin
            r = v[Y_W-1:0];
        end
        return r;
    endfunction
`endif

    logic signed [COEF_W-1:0] a_act_r, b_act_r, a_pend_r, b_pend_r;
    logic                     coef_busy_r;
    logic signed [ACC_W-1:0]  state_r [CH];

    logic [MUL_LAT-1:0]       stg_vld_r;
    logic [CW-1:0]            stg_ch_r [MUL_LAT];
    logic signed [ACC_W-1:0]  stg_pa_r [MUL_LAT];
    logic signed [ACC_W-1:0]  stg_pb_r [MUL_LAT];

    logic                     out_valid_r;
    logic [CW-1:0]            out_ch_r;
    logic [Y_W-1:0]           out_data_r;

    logic                     hazard_s, inflight_s, in_ready_s, accept_s, fire_s;
    logic signed [ACC_W-1:0]  x_ext_s, a_ext_s, b_ext_s, s_cur_s, s_new_s;
    logic [Y_W-1:0]           y_s;

    // Same-channel hazard: a sample of in_ch sits in a multiplier stage and has not yet written its state
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            hazard_s = hazard_s | (stg_vld_r[i] & (stg_ch_r[i] == in_ch));
        end
    end

    // Handshake and operand preparation; all arithmetic is done modulo 2^ACC_W, which is exact for the recursion
    always_comb begin
        inflight_s = |stg_vld_r;
        in_ready_s = ({1'b0, in_ch} < (CW + 1)'(CH)) & ~coef_busy_r & ~clr & ~hazard_s;
        accept_s   = in_valid & in_ready_s;
        x_ext_s    = ACC_W'($signed(in_data));
        a_ext_s    = ACC_W'(a_act_r);
        b_ext_s    = ACC_W'(b_act_r);
        s_cur_s    = state_r[in_ch];
        fire_s     = stg_vld_r[LAST] & ~clr;
        s_new_s    = stg_pa_r[LAST] + stg_pb_r[LAST];
    end

    // Output value selection: saturating or wrapping view of the new state
    always_comb begin
`ifdef IIR1_MULTICH_SAT_EN
        y_s = sat_y(s_new_s);
`else
        y_s = s_new_s[Y_W-1:0];
`endif
    end

    // Multiplier pipeline: products formed at accept, then delayed to the final add stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_r <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                stg_ch_r[i] <= '0;
                stg_pa_r[i] <= '0;
                stg_pb_r[i] <= '0;
            end
        end else begin
            stg_vld_r[0] <= accept_s;
            stg_ch_r[0]  <= in_ch;
            stg_pa_r[0]  <= a_ext_s * s_cur_s;
            stg_pb_r[0]  <= b_ext_s * x_ext_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                stg_vld_r[i] <= stg_vld_r[i-1] & ~clr;
                stg_ch_r[i]  <= stg_ch_r[i-1];
                stg_pa_r[i]  <= stg_pa_r[i-1];
                stg_pb_r[i]  <= stg_pb_r[i-1];
            end
        end
    end

    // Per-channel state memory; clr wipes it and blocks the write of any sample finishing this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                state_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < CH; i++) begin
                state_r[i] <= '0;
            end
        end else if (fire_s) begin
            state_r[stg_ch_r[LAST]] <= s_new_s;
        end
    end

    // Registered result strobe; outputs return to zero when no result is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_data_r  <= '0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= stg_ch_r[LAST];
            out_data_r  <= y_s;
        end else begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_data_r  <= '0;
        end
    end

    // Coefficient staging: a new request overwrites the pending pair; it goes live once no sample is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_act_r     <= COEF_W'(A_INIT);
            b_act_r     <= COEF_W'(B_INIT);
            a_pend_r    <= '0;
            b_pend_r    <= '0;
            coef_busy_r <= 1'b0;
        end else if (coef_we) begin
            a_pend_r    <= coef_a_in;
            b_pend_r    <= coef_b_in;
            coef_busy_r <= 1'b1;
        end else if (coef_busy_r && !inflight_s) begin
            a_act_r     <= a_pend_r;
            b_act_r     <= b_pend_r;
            coef_busy_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign coef_busy = coef_busy_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_data  = out_data_r;

endmodule
